// File: rtl/rv32i_trap_ctrl.sv
// rv32i_trap_ctrl: trap sequencer for the RV32I core.
// Arbitrates synchronous exceptions, interrupts, MRET and WFI. It stalls and
// drains the pipeline, then pulses the CSR file and issues flush plus a PC redirect.
// Every output is a register decoded from the next FSM state.
module rv32i_trap_ctrl #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] ADDR_MASK   = 32'h00FFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_mem_valid,
  input  logic [31:0] exc_mem_cause,
  input  logic [31:0] exc_mem_pc,
  input  logic [31:0] exc_mem_tval,
  input  logic        exc_dec_valid,
  input  logic [31:0] exc_dec_cause,
  input  logic [31:0] exc_dec_pc,
  input  logic [31:0] exc_dec_tval,
  input  logic        mret_req,
  input  logic        wfi_req,
  input  logic        mem_busy,
  input  logic        instr_boundary,
  input  logic [31:0] boundary_pc,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mip_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        exception_trigger,
  output logic [31:0] exception_cause,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_value,
  output logic        mret_trigger,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall_fetch
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_TRAP     = 3'd2,
    S_REDIRECT = 3'd3,
    S_MRET     = 3'd4,
    S_WFI      = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        latch_en;
  logic [31:0] cause_d;
  logic [31:0] pc_d;
  logic [31:0] tval_d;

  // Only MIE of mstatus matters here; the remaining bits are deliberately ignored.
  logic unused_mstatus;
  assign unused_mstatus = ^{mstatus_in[31:4], mstatus_in[2:0]};

  // Machine external (bit 11) and timer (bit 7) are the only interrupt sources.
  logic        irq_any;
  logic        irq_pend;
  logic [31:0] irq_cause;
  assign irq_any   = |(mip_in & mie_in & 32'h0000_0880);
  assign irq_pend  = mstatus_in[3] & irq_any;
  assign irq_cause = (mip_in[11] & mie_in[11]) ? 32'h8000_000B : 32'h8000_0007;

  // Trap target uses the already-latched cause, which is stable while in TRAP.
  logic [31:0] vec_base;
  logic [31:0] trap_target;
  logic        use_vector;
  assign vec_base    = mtvec_in & ADDR_MASK & ~32'h0000_0003;
  assign use_vector  = VECTORED_EN && (mtvec_in[1:0] == 2'b01) && exception_cause[31];
  assign trap_target = use_vector ?
                       ((vec_base + {26'b0, exception_cause[3:0], 2'b00}) & ADDR_MASK) :
                       vec_base;

  // Next-state and trap-latch selection; exc_mem always beats anything else.
  always_comb begin
    state_d  = S_IDLE;
    latch_en = 1'b0;
    cause_d  = exception_cause;
    pc_d     = exception_pc;
    tval_d   = exception_value;
    case (state_q)
      S_IDLE: begin
        if (exc_mem_valid) begin
          latch_en = 1'b1;
          cause_d  = exc_mem_cause;
          pc_d     = exc_mem_pc;
          tval_d   = exc_mem_tval;
          state_d  = S_TRAP;
        end else if (exc_dec_valid) begin
          latch_en = 1'b1;
          cause_d  = exc_dec_cause;
          pc_d     = exc_dec_pc;
          tval_d   = exc_dec_tval;
          state_d  = S_TRAP;
        end else if (irq_pend) begin
          state_d = S_DRAIN;
        end else if (mret_req) begin
          state_d = S_MRET;
        end else if (wfi_req) begin
          state_d = S_WFI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (exc_mem_valid) begin
          latch_en = 1'b1;
          cause_d  = exc_mem_cause;
          pc_d     = exc_mem_pc;
          tval_d   = exc_mem_tval;
          state_d  = S_TRAP;
        end else if (!irq_pend) begin
          state_d = S_IDLE;
        end else if (!mem_busy && instr_boundary) begin
          latch_en = 1'b1;
          cause_d  = irq_cause;
          pc_d     = boundary_pc;
          tval_d   = 32'h0;
          state_d  = S_TRAP;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_TRAP:     state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_MRET:     state_d = S_IDLE;
      S_WFI:      state_d = irq_any ? S_IDLE : S_WFI;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register plus registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      exception_trigger <= 1'b0;
      exception_cause   <= 32'h0;
      exception_pc      <= 32'h0;
      exception_value   <= 32'h0;
      mret_trigger      <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= 32'h0;
      flush             <= 1'b0;
      stall_fetch       <= 1'b0;
    end else begin
      state_q           <= state_d;
      exception_trigger <= (state_d == S_TRAP);
      mret_trigger      <= (state_d == S_MRET);
      redirect_valid    <= (state_d == S_REDIRECT) || (state_d == S_MRET);
      flush             <= (state_d == S_TRAP) || (state_d == S_REDIRECT) ||
                           (state_d == S_MRET);
      stall_fetch       <= (state_d == S_DRAIN) || (state_d == S_TRAP) ||
                           (state_d == S_WFI);
      if (latch_en) begin
        exception_cause <= cause_d;
        exception_pc    <= pc_d;
        exception_value <= tval_d;
      end
      if (state_d == S_REDIRECT) begin
        redirect_pc <= trap_target;
      end else if (state_d == S_MRET) begin
        redirect_pc <= mepc_in & ADDR_MASK;
      end
    end
  end

endmodule
